// File: rtl/data_memory.sv
// data_memory: byte-addressable data store for the Y86-64 memory stage.
// Quadword (8-byte) little-endian accesses at any byte address. Reads are
// combinational, writes and the synchronous clear happen on the clock edge.
// Out-of-range accesses raise dmemError and are never performed.
module data_memory #(
  parameter int MEM_BYTES  = 1024,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  memRead,
  input  logic                  memWrite,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  dmemError
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  // The last byte is computed one bit wider than the address, so an access
  // that wraps past the top of the address space lands out of range.
  logic [ADDR_WIDTH:0]              last_addr;
  logic                             valid;
  logic [IDX_W-1:0]                 base;
  logic [NUM_LANES-1:0][7:0]        rd_lanes;

  assign last_addr = {1'b0, address} + (ADDR_WIDTH+1)'(NUM_LANES - 1);
  assign valid     = last_addr <= (ADDR_WIDTH+1)'(MEM_BYTES - 1);

  // Only the low index bits matter once the access is known valid; for an
  // invalid access the lanes are gathered but the result is masked off.
  assign base = address[IDX_W-1:0];

  // Gather one byte per lane, lane k from address+k (little-endian).
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_rd_lane
    assign rd_lanes[k] = mem[base + IDX_W'(k)];
  end

  assign readData  = (resetn && memRead && valid) ? rd_lanes : '0;
  assign dmemError = (memRead | memWrite) & ~valid & resetn;

  // Synchronous clear has priority; otherwise commit a full in-range quadword.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (memWrite && valid) begin
      for (int k = 0; k < NUM_LANES; k++)
        mem[base + IDX_W'(k)] <= writeData[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory. Stimulus pushes the
// expected combinational response into a queue; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_data_memory;

  localparam int MEM_BYTES = 1024;

  logic        clock = 1'b0;
  logic        resetn;
  logic [63:0] address;
  logic [63:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [63:0] readData;
  logic        dmemError;

  data_memory #(.MEM_BYTES(MEM_BYTES), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clock(clock), .resetn(resetn), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .readData(readData),
    .dmemError(dmemError)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a plain byte array.
  byte unsigned ref_mem [MEM_BYTES];

  function automatic bit in_range(input logic [63:0] a);
    return a <= 64'(MEM_BYTES - 8);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] v = 64'h0;
    for (int k = 0; k < 8; k++) v = v | (64'(ref_mem[int'(a) + k]) << (8 * k));
    return v;
  endfunction

  // Apply one cycle of inputs, predict outputs, then advance the model
  // to what memory will hold after the coming edge.
  task automatic step(input string nm, input bit rn, input logic [63:0] a,
                      input logic [63:0] wd, input bit rd, input bit wr);
    exp_t e;
    @(posedge clock);
    #1;
    resetn = rn; address = a; writeData = wd; memRead = rd; memWrite = wr;
    e.name = nm;
    e.err  = rn && (rd || wr) && !in_range(a);
    e.data = (rn && rd && in_range(a)) ? ref_read(a) : 64'h0;
    q.push_back(e);
    if (!rn) begin
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    end else if (wr && in_range(a)) begin
      for (int k = 0; k < 8; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (readData !== e.data) begin
          bad++;
          $display("FAIL %s readData got=%h want=%h", e.name, readData, e.data);
        end
        total++;
        if (dmemError !== e.err) begin
          bad++;
          $display("FAIL %s dmemError got=%b want=%b", e.name, dmemError, e.err);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a;
    resetn = 1'b0; address = '0; writeData = '0; memRead = 1'b0; memWrite = 1'b0;

    // Directed sequence
    step("reset_with_write", 0, 64'd0, 64'hDEAD_BEEF_0000_1111, 1, 1);
    step("write0",           1, 64'd0, 64'h0123_4567_891b_cdef, 0, 1);
    step("read0",            1, 64'd0, 64'h0, 1, 0);
    step("read1_unaligned",  1, 64'd1, 64'h0, 1, 0);
    step("read7_endian",     1, 64'd7, 64'h0, 1, 0);
    step("rw3_old_data",     1, 64'd3, 64'hAA, 1, 1);
    step("read0_after_aa",   1, 64'd0, 64'h0, 1, 0);
    step("read3_after_aa",   1, 64'd3, 64'h0, 1, 0);
    step("write1016",        1, 64'd1016, 64'hCAFE_F00D_1234_5678, 1, 1);
    step("read1016",         1, 64'd1016, 64'h0, 1, 0);
    step("write1017_bad",    1, 64'd1017, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    step("read1016_kept",    1, 64'd1016, 64'h0, 1, 0);
    step("wrap_addr",        1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 1, 1);
    step("read0_after_wrap", 1, 64'd0, 64'h0, 1, 0);
    step("no_write_edge",    1, 64'd0, 64'h5555_5555_5555_5555, 1, 0);
    step("read_disabled",    1, 64'd0, 64'h0, 0, 0);
    step("idle_bad_addr",    1, 64'd2000, 64'h0, 0, 0);
    step("reset_low_read",   0, 64'd0, 64'h7777_7777_7777_7777, 1, 1);
    step("reset_low_bad",    0, 64'd5000, 64'h0, 1, 1);
    step("after_reset0",     1, 64'd0, 64'h0, 1, 0);
    step("after_reset1016",  1, 64'd1016, 64'h0, 1, 0);

    // Randomized traffic, biased toward a small region and the boundaries
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 64'($urandom_range(0, 40));
        6, 7:             a = 64'($urandom_range(1000, 1030));
        8:                a = {$urandom, $urandom};
        default:          a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      endcase
      step("random", ($urandom_range(0, 49) != 0), a, {$urandom, $urandom},
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
